// File: rtl/serial_tx_if.sv
// Producer-side handshake bundle for serial_tx: one word per tx_valid && tx_ready edge.
interface serial_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_BITS data bits LSB first, stop bit.
// The line is driven only from tx_r so the receiver never sees a glitch.
module serial_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_tx_if.slave  bus,
    output logic        tx,
    output logic        busy
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [BAUD_W-1:0]     baud_r, baud_s;
    logic [BIT_W-1:0]      bit_r, bit_s;
    logic [DATA_BITS-1:0]  shift_r, shift_s;
    logic                  tx_r, tx_s;
    logic                  ready_s;

    // Ready is decoded from registered state, which costs one idle cycle between frames.
    always_comb begin
        ready_s = (state_r == ST_IDLE);
    end

    assign bus.tx_ready = ready_s;
    assign busy         = ~ready_s;
    assign tx           = tx_r;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        tx_s    = tx_r;
        case (state_r)
            ST_IDLE: begin
                baud_s = '0;
                bit_s  = '0;
                if (bus.tx_valid) begin
                    shift_s = bus.tx_data;
                    state_s = ST_START;
                    tx_s    = 1'b0;
                end else begin
                    tx_s    = 1'b1;
                end
            end
            ST_START: begin
                if (baud_r == BAUD_MAX) begin
                    baud_s  = '0;
                    state_s = ST_DATA;
                    tx_s    = shift_r[0];
                end else begin
                    baud_s  = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_r == BAUD_MAX) begin
                    baud_s = '0;
                    if (bit_r == BIT_MAX) begin
                        bit_s   = '0;
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        // Next bit is shift_r[1]; shifting keeps the LSB at index 0.
                        bit_s   = bit_r + BIT_W'(1);
                        shift_s = shift_r >> 1;
                        tx_s    = shift_r[1];
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (baud_r == BAUD_MAX) begin
                    baud_s  = '0;
                    state_s = ST_IDLE;
                end else begin
                    baud_s  = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = '0;
                bit_s   = '0;
                shift_s = '0;
                tx_s    = 1'b1;
            end
        endcase
    end

    // State, counters, shift register and line flop; reset forces the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
        end
    end
endmodule
